// File: rtl/frame_payload_ctrl_if.sv
// Payload byte stream from frame_payload_ctrl to its consumer.
// valid/ready handshake with an end-of-frame marker.
interface frame_payload_ctrl_if;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/frame_payload_ctrl.sv
// Frame payload extractor: admits whole frames by buffer space, captures payload
// speculatively, commits on the last byte and rolls back when alignment is lost.
module frame_payload_ctrl #(
  parameter int unsigned FRAME_LEN  = 12,
  parameter int unsigned HDR_LEN    = 2,
  parameter int unsigned FIFO_DEPTH = 32,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    rx_data,
  input  logic [3:0]                    fr_byte_position,
  input  logic                          frame_detect,
  frame_payload_ctrl_if.master          m_if,
  input  logic                          clr_cnt,
  output logic [CNT_W-1:0]              frm_ok_cnt,
  output logic [CNT_W-1:0]              frm_drop_cnt,
  output logic [CNT_W-1:0]              frm_abort_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned AW          = $clog2(FIFO_DEPTH);
  localparam int unsigned PW          = AW + 1;
  localparam int unsigned PAYLOAD_LEN = FRAME_LEN - HDR_LEN;
  localparam logic [3:0]  HDR_POS     = 4'(HDR_LEN);
  localparam logic [3:0]  LAST_POS    = 4'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DROP} state_t;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } entry_t;

  state_t        state, state_nxt;
  logic [PW-1:0] wr_spec, wr_commit, rd;
  logic [PW-1:0] spec_nxt, commit_nxt, base, used;
  logic [PW:0]   free;
  logic [3:0]    prev_pos, pos_nxt;
  logic          wr_en, wr_last, run_idle;
  logic          ok_inc, drop_inc, abort_inc;
  logic          rd_en;
  entry_t        mem [FIFO_DEPTH];
  entry_t        rd_entry;

  // Next-state: capture/commit/rollback; an aborting cycle is re-evaluated as IDLE.
  always_comb begin
    state_nxt  = state;
    spec_nxt   = wr_spec;
    commit_nxt = wr_commit;
    pos_nxt    = prev_pos;
    base       = wr_spec;
    wr_en      = 1'b0;
    wr_last    = 1'b0;
    run_idle   = 1'b0;
    ok_inc     = 1'b0;
    drop_inc   = 1'b0;
    abort_inc  = 1'b0;
    used       = '0;
    free       = '0;
    case (state)
      S_IDLE: run_idle = 1'b1;
      S_CAPTURE: begin
        if (frame_detect && (fr_byte_position == prev_pos + 4'd1)) begin
          wr_en    = 1'b1;
          pos_nxt  = fr_byte_position;
          spec_nxt = wr_spec + PW'(1);
          if (fr_byte_position == LAST_POS) begin
            wr_last    = 1'b1;
            commit_nxt = wr_spec + PW'(1);
            ok_inc     = 1'b1;
            state_nxt  = S_IDLE;
          end
        end else begin
          abort_inc = 1'b1;
          spec_nxt  = wr_commit;
          base      = wr_commit;
          state_nxt = S_IDLE;
          run_idle  = 1'b1;
        end
      end
      S_DROP: begin
        if (!frame_detect || (fr_byte_position == LAST_POS)) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // Admission uses rd before this cycle's read, so it never over-admits.
    used = base - rd;
    free = (PW+1)'(FIFO_DEPTH) - (PW+1)'(used);
    if (run_idle && frame_detect && (fr_byte_position == HDR_POS)) begin
      if (free >= (PW+1)'(PAYLOAD_LEN)) begin
        wr_en     = 1'b1;
        spec_nxt  = base + PW'(1);
        pos_nxt   = fr_byte_position;
        state_nxt = S_CAPTURE;
      end else begin
        drop_inc  = 1'b1;
        state_nxt = S_DROP;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      wr_spec   <= '0;
      wr_commit <= '0;
      rd        <= '0;
      prev_pos  <= '0;
    end else begin
      state     <= state_nxt;
      wr_spec   <= spec_nxt;
      wr_commit <= commit_nxt;
      prev_pos  <= pos_nxt;
      if (rd_en) rd <= rd + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[base[AW-1:0]] <= '{last: wr_last, data: rx_data};
  end

  // Saturating statistics; a clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frm_ok_cnt    <= '0;
      frm_drop_cnt  <= '0;
      frm_abort_cnt <= '0;
    end else if (clr_cnt) begin
      frm_ok_cnt    <= '0;
      frm_drop_cnt  <= '0;
      frm_abort_cnt <= '0;
    end else begin
      if (ok_inc && (frm_ok_cnt != CNT_MAX))       frm_ok_cnt    <= frm_ok_cnt + CNT_W'(1);
      if (drop_inc && (frm_drop_cnt != CNT_MAX))   frm_drop_cnt  <= frm_drop_cnt + CNT_W'(1);
      if (abort_inc && (frm_abort_cnt != CNT_MAX)) frm_abort_cnt <= frm_abort_cnt + CNT_W'(1);
    end
  end

  assign rd_entry       = mem[rd[AW-1:0]];
  assign m_if.m_valid   = (rd != wr_commit);
  assign m_if.m_data    = m_if.m_valid ? rd_entry.data : 8'h00;
  assign m_if.m_last    = m_if.m_valid & rd_entry.last;
  assign rd_en          = m_if.m_valid & m_if.m_ready;
  assign fifo_level     = wr_commit - rd;

endmodule

// File: tb/tb_frame_payload_ctrl.sv
// Scoreboard bench for frame_payload_ctrl: expected payload entries are queued
// when a frame that should commit is driven, and popped on each handshake.
module tb_frame_payload_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic [3:0]  fr_byte_position;
  logic        frame_detect;
  logic        clr_cnt;
  logic [15:0] frm_ok_cnt, frm_drop_cnt, frm_abort_cnt;
  logic [5:0]  fifo_level;

  frame_payload_ctrl_if m_if ();

  frame_payload_ctrl dut (
    .clk              (clk),
    .reset            (reset),
    .rx_data          (rx_data),
    .fr_byte_position (fr_byte_position),
    .frame_detect     (frame_detect),
    .m_if             (m_if),
    .clr_cnt          (clr_cnt),
    .frm_ok_cnt       (frm_ok_cnt),
    .frm_drop_cnt     (frm_drop_cnt),
    .frm_abort_cnt    (frm_abort_cnt),
    .fifo_level       (fifo_level)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned n_pop = 0;
  logic [8:0]  sb_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Handshake completes at the next posedge when valid&ready hold at this negedge.
  always @(negedge clk) begin
    logic [8:0] e;
    if (reset && m_if.m_valid && m_if.m_ready) begin
      check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("m_data", 32'(m_if.m_data), 32'(e[7:0]));
        check("m_last", 32'(m_if.m_last), 32'(e[8]));
        n_pop++;
      end
    end
  end

  task automatic drive_byte(input logic det, input logic [3:0] pos, input logic [7:0] d);
    frame_detect     = det;
    fr_byte_position = pos;
    rx_data          = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_byte(1'b0, 4'd0, 8'h00);
  endtask

  // Payload bytes are 0x01..0x0A; headers are 0xA5/0xA6.
  task automatic send_frame(input bit commit, input bit clr_last, input bit lat);
    logic [7:0] d;
    for (int p = 0; p < 12; p++) begin
      d = (p < 2) ? 8'(8'hA5 + p) : 8'(p - 1);
      if (p == 11) begin
        if (commit)
          for (int k = 1; k <= 10; k++) sb_q.push_back({(k == 10), 8'(k)});
        if (clr_last) clr_cnt = 1'b1;
        if (lat) check("lat_pre", 32'(m_if.m_valid), 32'd0);
      end
      drive_byte(1'b1, 4'(p), d);
      clr_cnt = 1'b0;
      if (lat && p == 11) check("lat_post", 32'(m_if.m_valid), 32'd1);
    end
  endtask

  task automatic wait_drain(input int max_cyc);
    for (int i = 0; i < max_cyc && (sb_q.size() != 0 || m_if.m_valid); i++) idle(1);
    check("drain_q", 32'(sb_q.size()), 32'd0);
    check("drain_level", 32'(fifo_level), 32'd0);
  endtask

  task automatic clear_counters();
    clr_cnt = 1'b1;
    idle(1);
    clr_cnt = 1'b0;
    check("clr_ok", 32'(frm_ok_cnt), 32'd0);
    check("clr_drop", 32'(frm_drop_cnt), 32'd0);
    check("clr_abort", 32'(frm_abort_cnt), 32'd0);
  endtask

  initial begin
    int unsigned pop0;
    reset = 1'b0;
    clr_cnt = 1'b0;
    frame_detect = 1'b0;
    fr_byte_position = '0;
    rx_data = '0;
    m_if.m_ready = 1'b1;
    #2;
    check("rst_valid", 32'(m_if.m_valid), 32'd0);
    check("rst_data", 32'(m_if.m_data), 32'd0);
    check("rst_last", 32'(m_if.m_last), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_ok", 32'(frm_ok_cnt), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    idle(2);

    // Three back-to-back frames streaming out.
    pop0 = n_pop;
    send_frame(1'b1, 1'b0, 1'b1);
    send_frame(1'b1, 1'b0, 1'b0);
    send_frame(1'b1, 1'b0, 1'b0);
    wait_drain(100);
    check("t1_pops", n_pop - pop0, 32'd30);
    check("t1_ok", 32'(frm_ok_cnt), 32'd3);

    // Stalled consumer: fill, drop, exact-fit admission, then drain.
    clear_counters();
    m_if.m_ready = 1'b0;
    for (int f = 0; f < 3; f++) send_frame(1'b1, 1'b0, 1'b0);
    send_frame(1'b0, 1'b0, 1'b0);
    check("t2_level30", 32'(fifo_level), 32'd30);
    check("t2_drop1", 32'(frm_drop_cnt), 32'd1);
    check("t2_ok3", 32'(frm_ok_cnt), 32'd3);
    check("t2_hold_data", 32'(m_if.m_data), 32'd1);
    check("t2_hold_last", 32'(m_if.m_last), 32'd0);
    pop0 = n_pop;
    m_if.m_ready = 1'b1;
    idle(8);
    m_if.m_ready = 1'b0;
    check("t2_level22", 32'(fifo_level), 32'd22);
    send_frame(1'b1, 1'b0, 1'b0);
    check("t2_level32", 32'(fifo_level), 32'd32);
    send_frame(1'b0, 1'b0, 1'b0);
    check("t2_drop2", 32'(frm_drop_cnt), 32'd2);
    check("t2_level_full", 32'(fifo_level), 32'd32);
    m_if.m_ready = 1'b1;
    wait_drain(100);
    check("t2_pops", n_pop - pop0, 32'd40);

    // Lock lost at position 6.
    clear_counters();
    m_if.m_ready = 1'b0;
    send_frame(1'b1, 1'b0, 1'b0);
    for (int p = 0; p < 6; p++) drive_byte(1'b1, 4'(p), 8'(8'hE0 + p));
    drive_byte(1'b0, 4'd6, 8'hEE);
    idle(2);
    check("t3_abort", 32'(frm_abort_cnt), 32'd1);
    check("t3_level", 32'(fifo_level), 32'd10);
    send_frame(1'b1, 1'b0, 1'b0);
    check("t3_level20", 32'(fifo_level), 32'd20);
    check("t3_ok", 32'(frm_ok_cnt), 32'd2);
    m_if.m_ready = 1'b1;
    wait_drain(100);

    // Position jump 5 -> 8 during capture.
    clear_counters();
    for (int p = 0; p < 6; p++) drive_byte(1'b1, 4'(p), 8'(8'hC0 + p));
    for (int p = 8; p < 12; p++) drive_byte(1'b1, 4'(p), 8'(8'hC0 + p));
    check("t4_abort", 32'(frm_abort_cnt), 32'd1);
    check("t4_ok", 32'(frm_ok_cnt), 32'd0);
    check("t4_level", 32'(fifo_level), 32'd0);
    pop0 = n_pop;
    send_frame(1'b1, 1'b0, 1'b0);
    wait_drain(100);
    check("t4_pops", n_pop - pop0, 32'd10);

    // Asynchronous reset with committed and speculative bytes pending.
    m_if.m_ready = 1'b0;
    send_frame(1'b1, 1'b0, 1'b0);
    for (int p = 0; p < 4; p++) begin
      m_if.m_ready = p[0];
      drive_byte(1'b1, 4'(p), 8'(8'hB0 + p));
    end
    #2;
    reset = 1'b0;
    #1;
    check("t5_valid", 32'(m_if.m_valid), 32'd0);
    check("t5_data", 32'(m_if.m_data), 32'd0);
    check("t5_ok", 32'(frm_ok_cnt), 32'd0);
    check("t5_drop", 32'(frm_drop_cnt), 32'd0);
    check("t5_abort", 32'(frm_abort_cnt), 32'd0);
    check("t5_level", 32'(fifo_level), 32'd0);
    sb_q.delete();
    frame_detect = 1'b0;
    fr_byte_position = '0;
    @(posedge clk); #1;
    reset = 1'b1;
    m_if.m_ready = 1'b1;
    idle(1);
    pop0 = n_pop;
    send_frame(1'b1, 1'b0, 1'b0);
    wait_drain(100);
    check("t5_pops", n_pop - pop0, 32'd10);
    check("t5_ok1", 32'(frm_ok_cnt), 32'd1);

    // Clear on the commit edge wins, bytes still delivered.
    pop0 = n_pop;
    send_frame(1'b1, 1'b1, 1'b0);
    check("t6_ok", 32'(frm_ok_cnt), 32'd0);
    wait_drain(100);
    check("t6_pops", n_pop - pop0, 32'd10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/frame_payload_ctrl.md
Name: frame_payload_ctrl

Overview:
- Sits directly after frame_aligner. Consumes the aligned byte stream (rx_data, fr_byte_position, frame_detect) and forwards only the payload bytes of complete frames to a downstream consumer over a valid/ready interface.
- Admits or rejects each frame as a whole, based on buffer space.
- Rolls back partially captured frames when alignment is lost.
- Keeps frame statistics.

Parameters:
- FRAME_LEN, 12, total bytes per frame including header; fr_byte_position counts 0..FRAME_LEN-1.
- HDR_LEN, 2, header bytes at positions 0..HDR_LEN-1; payload is positions HDR_LEN..FRAME_LEN-1 (PAYLOAD_LEN = 10).
- FIFO_DEPTH, 32, payload buffer entries; power of 2, must be >= PAYLOAD_LEN.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk, input, 1, single clock; one rx byte per cycle.
- reset, input, 1, asynchronous, active-low reset.
- rx_data, input, 8, aligned byte from frame_aligner.
- fr_byte_position, input, 4, byte position in the current frame.
- frame_detect, input, 1, aligner is in frame lock.
- m_data, output, 8, payload byte.
- m_valid, output, 1, m_data is valid.
- m_ready, input, 1, consumer accepts the byte.
- m_last, output, 1, m_data is the last payload byte of a frame.
- clr_cnt, input, 1, synchronous clear of all statistics counters.
- frm_ok_cnt, output, CNT_W, frames committed.
- frm_drop_cnt, output, CNT_W, frames rejected for lack of space.
- frm_abort_cnt, output, CNT_W, frames abandoned mid-capture.
- fifo_level, output, $clog2(FIFO_DEPTH)+1, committed bytes currently in the buffer.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; all pointers, counters and fifo_level go to 0.
  - m_valid=0, m_last=0, m_data=0.
  - Takes effect immediately, even mid-frame; any partial frame is discarded and not counted.
- Buffer:
  - Each entry is {last, data}, 9 bits.
  - Write side has two pointers: wr_spec (speculative) and wr_commit.
  - Read side (rd) sees only entries below wr_commit.
- State machine (all inputs sampled on the rising clk edge):
  - IDLE: wait for frame_detect=1 and fr_byte_position==HDR_LEN.
    - If free = FIFO_DEPTH - (wr_spec - rd) >= PAYLOAD_LEN: write the byte, set wr_spec+1, go to CAPTURE.
    - Otherwise go to DROP.
  - CAPTURE: each cycle requires frame_detect=1 and fr_byte_position == previous position + 1.
    - If both hold: write the byte, with last=1 when position==FRAME_LEN-1.
    - On the last byte: wr_commit <= wr_spec+1, frm_ok_cnt++, go to IDLE.
    - On any violation (frame_detect=0 or unexpected position): wr_spec <= wr_commit, frm_abort_cnt++, go to IDLE. The violating cycle is itself evaluated as an IDLE cycle.
  - DROP: frm_drop_cnt++ on entry. Stay until position==FRAME_LEN-1 or frame_detect=0, then go to IDLE. Nothing is written.
  - Header bytes (positions < HDR_LEN) are never written.
- Latency: the last payload byte is sampled at edge N; m_valid for that frame's first byte is asserted after edge N (visible in cycle N+1) if the buffer was otherwise empty.
- Read handshake:
  - m_valid = (rd != wr_commit); m_data and m_last come from entry rd, registered or read-first.
  - rd advances on m_valid & m_ready.
  - m_data and m_last hold while m_valid=1 and m_ready=0.
- Simultaneous events:
  - A read and a write in the same cycle are both performed.
  - The admission check uses rd before that cycle's read (conservative).
  - Commit and read in the same cycle: fifo_level = old level + PAYLOAD_LEN - 1.
- Pointers are $clog2(FIFO_DEPTH)+1 bits and wrap naturally; full = PAYLOAD_LEN of free space not available.
- Counters: saturate at 2^CNT_W-1. clr_cnt=1 zeroes them on the next edge; a clear in the same cycle as an increment wins.
- fifo_level = wr_commit - rd.

Test Plan:
- Lock, 3 consecutive frames, payload bytes 0x01..0x0A each, m_ready=1:
  - 30 bytes out in order; m_last on every 10th byte.
  - frm_ok_cnt=3; first m_valid one cycle after position 11 is sampled.
- m_ready=0, 4 frames:
  - Frames 1–3 committed, fifo_level=30; frame 4 dropped (free=2), frm_drop_cnt=1.
  - m_ready=1 then drains exactly 30 bytes.
- frame_detect falls at position 6 mid-frame:
  - frm_abort_cnt=1, fifo_level unchanged, no partial bytes appear.
  - The next full frame is committed normally.
- Position jump 5->8 during capture -> abort counted; wr_spec restored.
- Reset asserted with 12 bytes buffered and m_ready toggling:
  - m_valid=0 and all counters=0 immediately.
  - After release, a clean frame outputs 10 bytes.
- clr_cnt asserted on the same edge as a commit -> frm_ok_cnt=0; the frame's bytes are still delivered.
